// File: rtl/victim_refill_ctrl.sv
// Cache miss controller: picks the PLRU victim, writes it back if dirty, refills the line from
// memory beat by beat, then updates the tag array and PLRU state.
module victim_refill_ctrl #(
  parameter int unsigned SETS   = 256,
  parameter int unsigned TAG_W  = 20,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned BEATS  = 4
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        MissValid,
  output logic                                        MissReady,
  input  logic [((SETS > 1) ? $clog2(SETS) : 1)-1:0]  MissSet,
  input  logic [TAG_W-1:0]                            MissTag,
  input  logic [1:0]                                  LRU_Way,
  output logic [((SETS > 1) ? $clog2(SETS) : 1)-1:0]  WriteSet,
  output logic [1:0]                                  WriteWay,
  output logic                                        WriteAccess,
  input  logic                                        VictimValid,
  input  logic                                        VictimDirty,
  input  logic [TAG_W-1:0]                            VictimTag,
  output logic                                        MemReq,
  output logic                                        MemWrite,
  input  logic                                        MemGnt,
  output logic [TAG_W+((SETS > 1) ? $clog2(SETS) : 1)-1:0] MemAddr,
  output logic [DATA_W-1:0]                           MemWData,
  output logic                                        MemWValid,
  input  logic                                        MemWReady,
  input  logic [DATA_W-1:0]                           MemRData,
  input  logic                                        MemRValid,
  output logic [((BEATS > 1) ? $clog2(BEATS) : 1)-1:0] ArrBeat,
  input  logic [DATA_W-1:0]                           ArrRData,
  output logic                                        ArrWE,
  output logic [DATA_W-1:0]                           ArrWData,
  output logic                                        TagWE,
  output logic                                        RefillDone
);

  localparam int unsigned SetW  = (SETS > 1) ? $clog2(SETS) : 1;
  localparam int unsigned BeatW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(BEATS - 1);

  typedef enum logic [2:0] {
    StIdle, StLookup, StWbReq, StWbData, StRfReq, StRfData, StUpdate
  } state_e;

  state_e            state_q, state_d;
  logic [SetW-1:0]   set_q, set_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [TAG_W-1:0]  vtag_q, vtag_d;
  logic [1:0]        way_q, way_d;
  logic [BeatW-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      set_q   <= '0;
      tag_q   <= '0;
      vtag_q  <= '0;
      way_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      tag_q   <= tag_d;
      vtag_q  <= vtag_d;
      way_q   <= way_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    set_d       = set_q;
    tag_d       = tag_q;
    vtag_d      = vtag_q;
    way_d       = way_q;
    cnt_d       = cnt_q;
    MissReady   = 1'b0;
    MemReq      = 1'b0;
    MemWrite    = 1'b0;
    MemWValid   = 1'b0;
    ArrWE       = 1'b0;
    TagWE       = 1'b0;
    WriteAccess = 1'b0;
    RefillDone  = 1'b0;
    unique case (state_q)
      StIdle: begin
        MissReady = 1'b1;
        if (MissValid) begin
          set_d   = MissSet;
          tag_d   = MissTag;
          state_d = StLookup;
        end
      end
      StLookup: begin
        way_d   = LRU_Way;
        vtag_d  = VictimTag;
        // An invalid line is never written back, whatever its dirty bit says.
        state_d = (VictimValid && VictimDirty) ? StWbReq : StRfReq;
      end
      StWbReq: begin
        MemReq   = 1'b1;
        MemWrite = 1'b1;
        if (MemGnt) begin
          cnt_d   = '0;
          state_d = StWbData;
        end
      end
      StWbData: begin
        MemWValid = 1'b1;
        if (MemWReady) begin
          cnt_d = (cnt_q == LastBeat) ? '0 : cnt_q + BeatW'(1);
          if (cnt_q == LastBeat) state_d = StRfReq;
        end
      end
      StRfReq: begin
        MemReq = 1'b1;
        if (MemGnt) begin
          cnt_d   = '0;
          state_d = StRfData;
        end
      end
      StRfData: begin
        if (MemRValid) begin
          ArrWE = 1'b1;
          cnt_d = (cnt_q == LastBeat) ? '0 : cnt_q + BeatW'(1);
          if (cnt_q == LastBeat) state_d = StUpdate;
        end
      end
      StUpdate: begin
        TagWE       = 1'b1;
        WriteAccess = 1'b1;
        RefillDone  = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Reset kills any burst in the same cycle it is asserted.
    if (rst) begin
      MissReady   = 1'b1;
      MemReq      = 1'b0;
      MemWrite    = 1'b0;
      MemWValid   = 1'b0;
      ArrWE       = 1'b0;
      TagWE       = 1'b0;
      WriteAccess = 1'b0;
      RefillDone  = 1'b0;
    end
  end

  always_comb begin
    WriteSet = rst ? '0 : set_q;
    WriteWay = rst ? '0 : way_q;
    ArrBeat  = rst ? '0 : cnt_q;
    if (rst) MemAddr = '0;
    else if (state_q == StWbReq) MemAddr = {vtag_q, set_q};
    else MemAddr = {tag_q, set_q};
  end

  assign MemWData = ArrRData;
  assign ArrWData = MemRData;

endmodule

// File: tb/tb_victim_refill_ctrl.sv
// Self-checking bench for victim_refill_ctrl: scripted misses against a memory responder, with a
// negedge monitor popping expected requests, beats and updates from scoreboard queues.
module tb_victim_refill_ctrl;

  localparam int unsigned SETS   = 256;
  localparam int unsigned TAG_W  = 20;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned BEATS  = 4;
  localparam int unsigned SetW   = 8;
  localparam int unsigned BeatW  = 2;
  localparam int unsigned AW     = TAG_W + SetW;

  logic              clk = 1'b0;
  logic              rst;
  logic              MissValid, MissReady;
  logic [SetW-1:0]   MissSet, WriteSet;
  logic [TAG_W-1:0]  MissTag, VictimTag;
  logic [1:0]        LRU_Way, WriteWay;
  logic              WriteAccess, VictimValid, VictimDirty;
  logic              MemReq, MemWrite, MemGnt, MemWValid, MemWReady, MemRValid;
  logic [AW-1:0]     MemAddr;
  logic [DATA_W-1:0] MemWData, MemRData, ArrRData, ArrWData;
  logic [BeatW-1:0]  ArrBeat;
  logic              ArrWE, TagWE, RefillDone;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wb_cnt = 0;
  int arr_cnt = 0;

  logic [AW:0]             exp_req_q[$];
  logic [BeatW+DATA_W-1:0] exp_wb_q[$];
  logic [BeatW+DATA_W-1:0] exp_arr_q[$];
  logic [SetW+1:0]         exp_upd_q[$];

  victim_refill_ctrl #(.SETS(SETS), .TAG_W(TAG_W), .DATA_W(DATA_W), .BEATS(BEATS)) dut (
    .clk(clk), .rst(rst), .MissValid(MissValid), .MissReady(MissReady), .MissSet(MissSet),
    .MissTag(MissTag), .LRU_Way(LRU_Way), .WriteSet(WriteSet), .WriteWay(WriteWay),
    .WriteAccess(WriteAccess), .VictimValid(VictimValid), .VictimDirty(VictimDirty),
    .VictimTag(VictimTag), .MemReq(MemReq), .MemWrite(MemWrite), .MemGnt(MemGnt),
    .MemAddr(MemAddr), .MemWData(MemWData), .MemWValid(MemWValid), .MemWReady(MemWReady),
    .MemRData(MemRData), .MemRValid(MemRValid), .ArrBeat(ArrBeat), .ArrRData(ArrRData),
    .ArrWE(ArrWE), .ArrWData(ArrWData), .TagWE(TagWE), .RefillDone(RefillDone)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] arr_model(input logic [SetW-1:0] s, input logic [1:0] w,
                                                  input logic [BeatW-1:0] b);
    return {16'hC0DE, 24'h0, s, 6'h0, w, 6'h0, b};
  endfunction

  assign ArrRData = arr_model(WriteSet, WriteWay, ArrBeat);

  always @(negedge clk) begin
    if (MemReq) begin
      checks++;
      if (exp_req_q.size() == 0) begin
        errors++;
        $display("FAIL mem_req: got write=%0b addr=%h, expected no request", MemWrite, MemAddr);
      end else begin
        if ({MemWrite, MemAddr} !== exp_req_q[0]) begin
          errors++;
          $display("FAIL mem_req: got write=%0b addr=%h, expected write=%0b addr=%h",
                   MemWrite, MemAddr, exp_req_q[0][AW], exp_req_q[0][AW-1:0]);
        end
        if (MemGnt) void'(exp_req_q.pop_front());
      end
    end
    if (MemWValid) begin
      checks++;
      if (exp_wb_q.size() == 0) begin
        errors++;
        $display("FAIL wb_beat: got beat=%0d data=%h, expected no write-back", ArrBeat, MemWData);
      end else begin
        if ({ArrBeat, MemWData} !== exp_wb_q[0]) begin
          errors++;
          $display("FAIL wb_beat: got beat=%0d data=%h, expected beat=%0d data=%h", ArrBeat,
                   MemWData, exp_wb_q[0][BeatW+DATA_W-1:DATA_W], exp_wb_q[0][DATA_W-1:0]);
        end
        if (MemWReady) begin
          void'(exp_wb_q.pop_front());
          wb_cnt++;
        end
      end
    end
    if (ArrWE) begin
      checks++;
      arr_cnt++;
      if (exp_arr_q.size() == 0) begin
        errors++;
        $display("FAIL arr_we: got beat=%0d data=%h, expected no array write", ArrBeat, ArrWData);
      end else begin
        if ({ArrBeat, ArrWData} !== exp_arr_q[0]) begin
          errors++;
          $display("FAIL arr_we: got beat=%0d data=%h, expected beat=%0d data=%h", ArrBeat,
                   ArrWData, exp_arr_q[0][BeatW+DATA_W-1:DATA_W], exp_arr_q[0][DATA_W-1:0]);
        end
        void'(exp_arr_q.pop_front());
      end
    end
    if (TagWE || WriteAccess || RefillDone) begin
      checks++;
      if (exp_upd_q.size() == 0) begin
        errors++;
        $display("FAIL update: got tagwe=%0b acc=%0b done=%0b, expected no update", TagWE,
                 WriteAccess, RefillDone);
      end else begin
        if ({TagWE, WriteAccess, RefillDone, WriteWay, WriteSet} !== {3'b111, exp_upd_q[0]}) begin
          errors++;
          $display("FAIL update: got tagwe=%0b acc=%0b done=%0b way=%0d set=%0d, expected 1 1 1 way=%0d set=%0d",
                   TagWE, WriteAccess, RefillDone, WriteWay, WriteSet, exp_upd_q[0][SetW+1:SetW],
                   exp_upd_q[0][SetW-1:0]);
        end
        void'(exp_upd_q.pop_front());
      end
    end
  end

  // Runs one miss end to end; abort_beat >= 0 pulses rst on that refill beat instead.
  task automatic do_miss(input logic [SetW-1:0] s, input logic [TAG_W-1:0] t, input logic [1:0] w,
                         input logic vv, input logic vd, input logic [TAG_W-1:0] vt,
                         input int gnt_delay, input bit wr_toggle, input bit spurious,
                         input int abort_beat, input bit keep_valid,
                         output int acc_cyc, output int done_cyc);
    int n, gcnt, rbeats, budget;
    bit rf_active, rf_next;
    logic [BeatW-1:0] bb;
    MissValid = 1'b1;
    MissSet   = s;
    MissTag   = t;
    budget    = 0;
    acc_cyc   = -1;
    done_cyc  = -1;
    while (!MissReady && budget < 20) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!MissReady) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got MissReady=0 for 20 cycles, expected 1");
      return;
    end
    @(posedge clk); #1;
    if (!keep_valid) MissValid = 1'b0;
    acc_cyc     = cyc;
    LRU_Way     = w;
    VictimValid = vv;
    VictimDirty = vd;
    VictimTag   = vt;
    if (vv && vd) begin
      exp_req_q.push_back({1'b1, vt, s});
      for (int b = 0; b < BEATS; b++) begin
        bb = b[BeatW-1:0];
        exp_wb_q.push_back({bb, arr_model(s, w, bb)});
      end
    end
    exp_req_q.push_back({1'b0, t, s});
    if (abort_beat < 0) exp_upd_q.push_back({w, s});
    gcnt = 0; rbeats = 0; rf_active = 0; rf_next = 0; n = 0;
    while (n < 300) begin
      MemGnt    = 1'b0;
      MemRValid = 1'b0;
      if (RefillDone) begin
        done_cyc = cyc;
        break;
      end
      if (rf_next) rf_active = 1;
      if (MemReq) begin
        if (gcnt < gnt_delay) gcnt++;
        else begin
          MemGnt = 1'b1;
          gcnt   = 0;
          if (!MemWrite) rf_next = 1;
        end
      end
      MemWReady = wr_toggle ? cyc[0] : 1'b1;
      if (spurious && MemWValid) begin
        MemRValid = 1'b1;
        MemRData  = {$urandom, $urandom};
      end
      if (rf_active && rbeats < BEATS) begin
        MemRValid = 1'b1;
        MemRData  = {$urandom, $urandom};
        if (rbeats == abort_beat) begin
          rst = 1'b1;
          @(posedge clk); #1;
          rst       = 1'b0;
          MemRValid = 1'b0;
          return;
        end
        bb = rbeats[BeatW-1:0];
        exp_arr_q.push_back({bb, MemRData});
        rbeats++;
      end
      @(posedge clk); #1;
      n++;
    end
    if (done_cyc < 0) begin
      checks++;
      errors++;
      $display("FAIL refill_timeout: got no RefillDone in 300 cycles, expected one");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({MissReady, MemReq, MemWrite, MemWValid, ArrWE, TagWE, WriteAccess, RefillDone} !== 8'h80) begin
        errors++;
        $display("FAIL reset_ctrl[%0d]: got %b, expected 10000000", i, {MissReady, MemReq,
                 MemWrite, MemWValid, ArrWE, TagWE, WriteAccess, RefillDone});
      end
      checks++;
      if ({WriteSet, MemAddr, WriteWay, ArrBeat} !== '0) begin
        errors++;
        $display("FAIL reset_regs[%0d]: got set=%h addr=%h way=%0d beat=%0d, expected all 0", i,
                 WriteSet, MemAddr, WriteWay, ArrBeat);
      end
      rst = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_clean_miss();
    int a, d;
    do_miss(8'd5, 20'hABCDE, 2'd2, 1'b0, 1'b0, 20'h0, 0, 0, 0, -1, 0, a, d);
    checks++;
    if (d - a !== 2 + BEATS) begin
      errors++;
      $display("FAIL clean_latency: got %0d, expected %0d", d - a + 1, 3 + BEATS);
    end
    // Dirty but invalid victim must still skip the write-back.
    do_miss(8'd77, 20'h12345, 2'd1, 1'b0, 1'b1, 20'hFFFFF, 0, 0, 0, -1, 0, a, d);
    checks++;
    if (d - a !== 2 + BEATS) begin
      errors++;
      $display("FAIL invalid_dirty_latency: got %0d, expected %0d", d - a + 1, 3 + BEATS);
    end
    @(posedge clk); #1;
    checks++;
    if (exp_req_q.size() + exp_wb_q.size() + exp_arr_q.size() + exp_upd_q.size() != 0) begin
      errors++;
      $display("FAIL clean_drain: got %0d outstanding, expected 0", exp_req_q.size() +
               exp_wb_q.size() + exp_arr_q.size() + exp_upd_q.size());
    end
  endtask

  task automatic test_dirty_miss();
    int a, d, w0;
    w0 = wb_cnt;
    do_miss(8'd33, 20'h55555, 2'd3, 1'b1, 1'b1, 20'h0001A, 0, 0, 0, -1, 0, a, d);
    checks++;
    if (d - a !== 3 + 2 * BEATS) begin
      errors++;
      $display("FAIL dirty_latency: got %0d, expected %0d", d - a + 1, 4 + 2 * BEATS);
    end
    @(posedge clk); #1;
    checks++;
    if (wb_cnt - w0 !== BEATS || exp_wb_q.size() + exp_upd_q.size() != 0) begin
      errors++;
      $display("FAIL dirty_beats: got %0d beats, expected %0d", wb_cnt - w0, BEATS);
    end
  endtask

  task automatic test_stalls();
    int a, d, w0, r0;
    w0 = wb_cnt;
    r0 = arr_cnt;
    do_miss(8'd200, 20'h0F0F0, 2'd0, 1'b1, 1'b1, 20'hBEEF1, 3, 1, 0, -1, 0, a, d);
    @(posedge clk); #1;
    checks++;
    if (wb_cnt - w0 !== BEATS || arr_cnt - r0 !== BEATS) begin
      errors++;
      $display("FAIL stall_beats: got wb=%0d arr=%0d, expected %0d each", wb_cnt - w0,
               arr_cnt - r0, BEATS);
    end
    checks++;
    if (exp_req_q.size() + exp_wb_q.size() + exp_arr_q.size() + exp_upd_q.size() != 0) begin
      errors++;
      $display("FAIL stall_drain: got %0d outstanding, expected 0", exp_req_q.size() +
               exp_wb_q.size() + exp_arr_q.size() + exp_upd_q.size());
    end
  endtask

  task automatic test_spurious();
    int a, d, r0;
    r0 = arr_cnt;
    for (int i = 0; i < 2; i++) begin
      MemRValid = 1'b1;
      MemRData  = {$urandom, $urandom};
      #3;
      checks++;
      if (ArrWE !== 1'b0) begin
        errors++;
        $display("FAIL spurious_idle[%0d]: got ArrWE=%b, expected 0", i, ArrWE);
      end
      @(posedge clk); #1;
    end
    MemRValid = 1'b0;
    do_miss(8'd17, 20'h77777, 2'd2, 1'b1, 1'b1, 20'h00042, 0, 0, 1, -1, 0, a, d);
    @(posedge clk); #1;
    checks++;
    if (arr_cnt - r0 !== BEATS) begin
      errors++;
      $display("FAIL spurious_writes: got %0d, expected %0d", arr_cnt - r0, BEATS);
    end
  endtask

  task automatic test_reset_mid_burst();
    int a, d, r0;
    r0 = arr_cnt;
    do_miss(8'd99, 20'h31415, 2'd1, 1'b0, 1'b0, 20'h0, 0, 0, 0, 2, 0, a, d);
    checks++;
    if ({MissReady, TagWE, WriteAccess, ArrWE, MemReq} !== 5'b10000 || WriteSet !== '0) begin
      errors++;
      $display("FAIL abort_state: got rdy=%b tagwe=%b acc=%b we=%b req=%b set=%0d, expected 1 0 0 0 0 set=0",
               MissReady, TagWE, WriteAccess, ArrWE, MemReq, WriteSet);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (arr_cnt - r0 !== 2 || exp_upd_q.size() != 0 || exp_arr_q.size() != 0) begin
      errors++;
      $display("FAIL abort_writes: got %0d array writes, expected 2", arr_cnt - r0);
    end
  endtask

  task automatic test_back_to_back();
    int a1, d1, a2, d2;
    do_miss(8'd9, 20'hAAAAA, 2'd1, 1'b0, 1'b0, 20'h0, 0, 0, 0, -1, 1, a1, d1);
    checks++;
    if (MissReady !== 1'b0) begin
      errors++;
      $display("FAIL b2b_update_ready: got %b, expected 0", MissReady);
    end
    do_miss(8'd10, 20'hBBBBB, 2'd3, 1'b0, 1'b0, 20'h0, 0, 0, 0, -1, 0, a2, d2);
    checks++;
    if (a2 - d1 !== 2) begin
      errors++;
      $display("FAIL b2b_accept: got %0d cycles after RefillDone, expected 1", a2 - d1 - 1);
    end
    @(posedge clk); #1;
    checks++;
    if (exp_req_q.size() + exp_wb_q.size() + exp_arr_q.size() + exp_upd_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain: got %0d outstanding, expected 0", exp_req_q.size() +
               exp_wb_q.size() + exp_arr_q.size() + exp_upd_q.size());
    end
  endtask

  initial begin
    rst = 1'b1; MissValid = 1'b0; MissSet = '0; MissTag = '0; LRU_Way = '0;
    VictimValid = 1'b0; VictimDirty = 1'b0; VictimTag = '0; MemGnt = 1'b0;
    MemWReady = 1'b0; MemRData = '0; MemRValid = 1'b0;
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_stalls();
    test_spurious();
    test_reset_mid_burst();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish by 200000, expected earlier finish");
    $fatal(1, "timeout");
  end

endmodule
